// File: rtl/accbin_stream_if.sv
// Stream bundle for accbin_stream: partial-sum input beats in, binarised
// pixel beats out, both with valid/ready handshakes.
interface accbin_stream_if #(
  parameter int BW    = 8,
  parameter int TERMS = 5,
  parameter int LANES = 24,
  parameter int N_CH  = 18,
  parameter int N_PIX = 576
);
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GRPW = ((N_PIX / LANES) > 1) ? $clog2(N_PIX / LANES) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*TERMS*BW-1:0]   in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0]            out_bits;
  logic [CHW-1:0]              out_ch;
  logic [GRPW-1:0]             out_grp;
  logic                        out_last;

  // Producer / consumer side (drives input beats, accepts results)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bits, out_ch, out_grp, out_last
  );

  // Accumulate-and-binarise stage side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bits, out_ch, out_grp, out_last
  );
endinterface

// File: rtl/accbin_stream.sv
// Time-multiplexed accumulate-and-binarise stage. Walks N_CH channels x
// N_PIX/LANES pixel groups per frame; each group accumulates ACC_BEATS input
// beats of TERMS signed terms per lane, adds the channel offset and emits the
// sign bit (sum >= 0 -> 1) per lane through a one-deep output register.
module accbin_stream #(
  parameter int BW        = 8,
  parameter int TERMS     = 5,
  parameter int LANES     = 24,
  parameter int N_CH      = 18,
  parameter int N_PIX     = 576,
  parameter int ACC_BEATS = 1,
  parameter int ACCW      = BW + $clog2(TERMS * ACC_BEATS) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_addr,
  input  logic [ACCW-1:0]                        cfg_offset,
  accbin_stream_if.slave                         bus,
  output logic                                   busy,
  output logic                                   frame_done
);
  localparam int NGRP = N_PIX / LANES;
  localparam int DW   = LANES * TERMS * BW;
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GRPW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int BTW  = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Sign-extend one BW-bit term to accumulator width
  function automatic logic [ACCW-1:0] sext_term(input logic [BW-1:0] t);
    return {{(ACCW-BW){t[BW-1]}}, t};
  endfunction

  logic [1:0]      r_state;
  logic [BTW-1:0]  r_beat;
  logic [GRPW-1:0] r_grp;
  logic [CHW-1:0]  r_ch;
  logic [ACCW-1:0] r_acc    [LANES];
  logic [ACCW-1:0] r_offset [N_CH];
  logic            r_out_valid;
  logic [LANES-1:0] r_out_bits;
  logic [CHW-1:0]  r_out_ch;
  logic [GRPW-1:0] r_out_grp;
  logic            r_out_last;
  logic            r_frame_done;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_out_fire;
  logic            w_beat_last;
  logic            w_grp_last;
  logic            w_ch_last;
  logic            w_cfg_hit;
  logic [ACCW-1:0] w_off;
  logic [ACCW-1:0] w_acc_next [LANES];
  logic [ACCW:0]   w_sum      [LANES];
  logic [LANES-1:0] w_bits;

  assign w_in_ready  = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept    = w_in_ready && bus.in_valid;
  assign w_out_fire  = r_out_valid && bus.out_ready;
  assign w_beat_last = (r_beat == BTW'(ACC_BEATS - 1));
  assign w_grp_last  = (r_grp == GRPW'(NGRP - 1));
  assign w_ch_last   = (r_ch == CHW'(N_CH - 1));
  assign w_cfg_hit   = (r_state == S_IDLE) && cfg_we &&
                       ({1'b0, cfg_addr} < (CHW+1)'(N_CH));
  assign w_off       = r_offset[r_ch];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bits  = r_out_bits;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_grp   = r_out_grp;
  assign bus.out_last  = r_out_last;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_frame_done;

  // Per-lane running sum (restarts on beat 0) and offset-adjusted sign bit
  always_comb begin
    w_bits = {LANES{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      if (r_beat == {BTW{1'b0}}) begin
        w_acc_next[l] = {ACCW{1'b0}};
      end else begin
        w_acc_next[l] = r_acc[l];
      end
      for (int t = 0; t < TERMS; t++) begin
        w_acc_next[l] = w_acc_next[l] +
                        sext_term(bus.in_data[DW-1-(l*TERMS+t)*BW -: BW]);
      end
      w_sum[l] = {w_acc_next[l][ACCW-1], w_acc_next[l]} + {w_off[ACCW-1], w_off};
      w_bits[LANES-1-l] = ~w_sum[l][ACCW];
    end
  end

  // Frame sequencing: beat innermost, then pixel group, then channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= {BTW{1'b0}};
      r_grp   <= {GRPW{1'b0}};
      r_ch    <= {CHW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_beat  <= {BTW{1'b0}};
            r_grp   <= {GRPW{1'b0}};
            r_ch    <= {CHW{1'b0}};
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_beat_last) begin
              r_beat <= {BTW{1'b0}};
              if (w_grp_last) begin
                r_grp <= {GRPW{1'b0}};
                if (w_ch_last) begin
                  r_ch    <= {CHW{1'b0}};
                  r_state <= S_DRAIN;
                end else begin
                  r_ch <= r_ch + CHW'(1);
                end
              end else begin
                r_grp <= r_grp + GRPW'(1);
              end
            end else begin
              r_beat <= r_beat + BTW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_out_fire && r_out_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane accumulators: cleared at frame start, updated on every accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) r_acc[l] <= {ACCW{1'b0}};
    end else if ((r_state == S_IDLE) && start) begin
      for (int l = 0; l < LANES; l++) r_acc[l] <= {ACCW{1'b0}};
    end else if (w_accept) begin
      for (int l = 0; l < LANES; l++) r_acc[l] <= w_acc_next[l];
    end
  end

  // Per-channel offset table, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) r_offset[c] <= {ACCW{1'b0}};
    end else if (w_cfg_hit) begin
      r_offset[cfg_addr] <= cfg_offset;
    end
  end

  // Output register: loads on a group's final beat, may drain and refill at once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_bits   <= {LANES{1'b0}};
      r_out_ch     <= {CHW{1'b0}};
      r_out_grp    <= {GRPW{1'b0}};
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_out_fire && r_out_last;
      if (w_accept && w_beat_last) begin
        r_out_valid <= 1'b1;
        r_out_bits  <= w_bits;
        r_out_ch    <= r_ch;
        r_out_grp   <= r_grp;
        r_out_last  <= w_ch_last && w_grp_last;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_accbin_stream.sv
// Bench for accbin_stream: a small ACC_BEATS=3 instance driven from a table
// of hand-computed groups, and a default-size instance streamed with directed
// and random beats against a reference model and output scoreboard.
module tb_accbin_stream;
  localparam int B_DW = 24 * 5 * 8;
  localparam int S_DW = 2 * 5 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- default-size instance ----------------
  logic        rst_b, start_b, we_b;
  logic [4:0]  addr_b;
  logic [11:0] off_b;
  logic        busy_b, fd_b;
  accbin_stream_if #(.BW(8), .TERMS(5), .LANES(24), .N_CH(18), .N_PIX(576)) b_if ();
  accbin_stream #(.BW(8), .TERMS(5), .LANES(24), .N_CH(18), .N_PIX(576), .ACC_BEATS(1)) u_big (
    .clk(clk), .rst(rst_b), .start(start_b), .cfg_we(we_b), .cfg_addr(addr_b),
    .cfg_offset(off_b), .bus(b_if), .busy(busy_b), .frame_done(fd_b)
  );

  // ---------------- small multi-beat instance ----------------
  logic        rst_s, start_s, we_s;
  logic [0:0]  addr_s;
  logic [12:0] off_s;
  logic        busy_s, fd_s;
  accbin_stream_if #(.BW(8), .TERMS(5), .LANES(2), .N_CH(2), .N_PIX(4)) s_if ();
  accbin_stream #(.BW(8), .TERMS(5), .LANES(2), .N_CH(2), .N_PIX(4), .ACC_BEATS(3)) u_sml (
    .clk(clk), .rst(rst_s), .start(start_s), .cfg_we(we_s), .cfg_addr(addr_s),
    .cfg_offset(off_s), .bus(s_if), .busy(busy_s), .frame_done(fd_s)
  );

  typedef struct packed {
    logic [23:0] bits;
    logic [4:0]  ch;
    logic [4:0]  grp;
    logic        last;
  } bexp_t;

  typedef struct packed {
    logic [2:0][1:0][39:0] t;   // [beat][lane] five packed terms
    logic [1:0]            bits;
    logic                  ch;
    logic                  grp;
    logic                  last;
    logic                  stall;
  } svec_t;

  bexp_t b_q[$];
  svec_t tbl[4];
  int    off_m[18];
  int    m_ch, m_grp, n_out_b;
  int    last_cyc = -10;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] mk(input int a, input int b, input int c, input int d, input int e);
    return {a[7:0], b[7:0], c[7:0], d[7:0], e[7:0]};
  endfunction

  // Reference: per lane, sum of five signed terms plus offset, bit = (sum >= 0)
  function automatic logic [23:0] model_bits(input logic [B_DW-1:0] d, input int off);
    logic [23:0] r;
    int s;
    r = 24'd0;
    for (int l = 0; l < 24; l++) begin
      s = off;
      for (int t = 0; t < 5; t++) s += int'($signed(d[B_DW-1-(l*5+t)*8 -: 8]));
      r[23-l] = (s >= 0);
    end
    return r;
  endfunction

  task automatic gen_rand(output logic [B_DW-1:0] d);
    for (int k = 0; k < 120; k++) d[k*8 +: 8] = 8'($urandom_range(0, 255));
  endtask

  task automatic cfg_b(input int a, input int v);
    we_b = 1'b1; addr_b = 5'(a); off_b = 12'(v);
    @(posedge clk); #1;
    we_b = 1'b0;
  endtask

  task automatic cfg_s(input int a, input int v);
    we_s = 1'b1; addr_s = 1'(a); off_s = 13'(v);
    @(posedge clk); #1;
    we_s = 1'b0;
  endtask

  task automatic big_start();
    m_ch = 0; m_grp = 0; n_out_b = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("b_busy_run", busy_b, 1);
  endtask

  // Present one beat, wait (bounded) for acceptance, record expected result
  task automatic big_send(input logic [B_DW-1:0] d, output int waits);
    bexp_t e;
    b_if.in_data  = d;
    b_if.in_valid = 1'b1;
    #1;
    waits = 0;
    while (!b_if.in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("b_accept", b_if.in_ready, 1);
    e.bits = model_bits(d, off_m[m_ch]);
    e.ch   = 5'(m_ch);
    e.grp  = 5'(m_grp);
    e.last = (m_ch == 17) && (m_grp == 23);
    b_q.push_back(e);
    if (m_grp == 23) begin
      m_grp = 0;
      m_ch  = (m_ch == 17) ? 0 : m_ch + 1;
    end else begin
      m_grp++;
    end
    @(posedge clk); #1;
    b_if.in_valid = 1'b0;
  endtask

  task automatic big_finish();
    int n;
    n = 0;
    while (!fd_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_done_seen", fd_b, 1);
    chk("b_out_count", n_out_b, 432);
    chk("b_q_empty", b_q.size(), 0);
    chk("b_busy_idle", busy_b, 0);
    @(posedge clk); #1;
    chk("b_done_pulse", fd_b, 0);
  endtask

  // Default-instance output scoreboard and frame_done timing
  initial begin
    bexp_t e;
    forever begin
      @(negedge clk);
      if (rst_b === 1'b0) begin
        if (b_if.out_valid && b_if.out_ready) begin
          if (b_q.size() == 0) begin
            chk("b_unexpected_out", 1, 0);
          end else begin
            e = b_q.pop_front();
            chk("b_bits", b_if.out_bits, e.bits);
            chk("b_ch", b_if.out_ch, e.ch);
            chk("b_grp", b_if.out_grp, e.grp);
            chk("b_last", b_if.out_last, e.last);
            if (e.last) last_cyc = cyc;
            n_out_b++;
          end
        end
        if (fd_b) begin
          chk("b_done_timing", cyc, last_cyc + 1);
          chk("b_done_busy", busy_b, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [B_DW-1:0] d;
    int w;

    // ---------- reset with start and in_valid asserted ----------
    rst_b = 1'b1; rst_s = 1'b1; start_b = 1'b1; start_s = 1'b1;
    we_b = 1'b0; we_s = 1'b0; addr_b = 5'd0; addr_s = 1'b0; off_b = 12'd0; off_s = 13'd0;
    b_if.in_valid = 1'b1; b_if.in_data = '0; b_if.out_ready = 1'b1;
    s_if.in_valid = 1'b1; s_if.in_data = '0; s_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_rst_in_ready", b_if.in_ready, 0);
    chk("b_rst_out_valid", b_if.out_valid, 0);
    chk("b_rst_out_bits", b_if.out_bits, 0);
    chk("b_rst_out_ch", b_if.out_ch, 0);
    chk("b_rst_out_grp", b_if.out_grp, 0);
    chk("b_rst_out_last", b_if.out_last, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_done", fd_b, 0);
    chk("s_rst_in_ready", s_if.in_ready, 0);
    chk("s_rst_out_valid", s_if.out_valid, 0);
    chk("s_rst_busy", busy_s, 0);
    rst_b = 1'b0; rst_s = 1'b0; start_b = 1'b0; start_s = 1'b0;
    b_if.in_valid = 1'b0; s_if.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_post_rst_busy", busy_b, 0);
    chk("b_post_rst_valid", b_if.out_valid, 0);

    // ---------- small instance: ACC_BEATS=3, table of groups ----------
    for (int r = 0; r < 4; r++) tbl[r] = '0;
    // ch0 grp0: lane0 +4,-6,+1 = -1 (off 0) -> 0 ; lane1 +10 -> 1
    tbl[0].t[0][0] = mk(4, 0, 0, 0, 0);
    tbl[0].t[1][0] = mk(-2, -2, -2, 0, 0);
    tbl[0].t[2][0] = mk(0, 0, 0, 0, 1);
    tbl[0].t[0][1] = mk(10, 0, 0, 0, 0);
    tbl[0].bits = 2'b01; tbl[0].ch = 1'b0; tbl[0].grp = 1'b0; tbl[0].last = 1'b0;
    // ch0 grp1: lane0 0 -> 1 ; lane1 -1 -> 0 (fresh accumulation each group)
    tbl[1].t[0][1] = mk(0, 0, 0, 0, -1);
    tbl[1].bits = 2'b10; tbl[1].ch = 1'b0; tbl[1].grp = 1'b1; tbl[1].last = 1'b0; tbl[1].stall = 1'b1;
    // ch1 grp0 (off +1): lane0 -1+1 = 0 -> 1 ; lane1 -2+1 = -1 -> 0
    tbl[2].t[0][0] = mk(4, 0, 0, 0, 0);
    tbl[2].t[1][0] = mk(-2, -2, -2, 0, 0);
    tbl[2].t[2][0] = mk(0, 0, 0, 0, 1);
    tbl[2].t[0][1] = mk(-1, -1, 0, 0, 0);
    tbl[2].bits = 2'b10; tbl[2].ch = 1'b1; tbl[2].grp = 1'b0; tbl[2].last = 1'b0;
    // ch1 grp1 (off +1): lane0 15*-128+1 = -1919 -> 0 ; lane1 15*127+1 = 1906 -> 1
    for (int b = 0; b < 3; b++) begin
      tbl[3].t[b][0] = mk(-128, -128, -128, -128, -128);
      tbl[3].t[b][1] = mk(127, 127, 127, 127, 127);
    end
    tbl[3].bits = 2'b01; tbl[3].ch = 1'b1; tbl[3].grp = 1'b1; tbl[3].last = 1'b1; tbl[3].stall = 1'b1;

    cfg_s(0, 0);
    cfg_s(1, 1);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    chk("s_busy_run", busy_s, 1);
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 3; b++) begin
        s_if.in_data  = {tbl[r].t[b][0], tbl[r].t[b][1]};
        s_if.in_valid = 1'b1;
        #1;
        w = 0;
        while (!s_if.in_ready && w < 20) begin
          @(posedge clk); #1;
          w++;
        end
        chk("s_wait", w, 0);
        @(posedge clk); #1;
        s_if.in_valid = 1'b0;
        if (b == 2) begin
          chk($sformatf("s_valid%0d", r), s_if.out_valid, 1);
          chk($sformatf("s_bits%0d", r), s_if.out_bits, tbl[r].bits);
          chk($sformatf("s_ch%0d", r), s_if.out_ch, tbl[r].ch);
          chk($sformatf("s_grp%0d", r), s_if.out_grp, tbl[r].grp);
          chk($sformatf("s_last%0d", r), s_if.out_last, tbl[r].last);
        end else begin
          chk($sformatf("s_midbeat_valid%0d", r), s_if.out_valid, 0);
        end
        if (tbl[r].stall && b == 0) begin
          repeat (2) begin
            @(posedge clk); #1;
            chk("s_stall_valid", s_if.out_valid, 0);
          end
        end
      end
    end
    @(posedge clk); #1;
    chk("s_done", fd_s, 1);
    chk("s_busy_idle", busy_s, 0);
    chk("s_out_drained", s_if.out_valid, 0);
    @(posedge clk); #1;
    chk("s_done_pulse", fd_s, 0);

    // ---------- default instance, frame 1: configured offsets ----------
    for (int c = 0; c < 18; c++) off_m[c] = ((c * 37) % 41) - 20;
    off_m[0] = -3;
    off_m[5] = -2000;
    for (int c = 0; c < 18; c++) cfg_b(c, off_m[c]);
    cfg_b(18, 1000);   // out-of-range channel: must be dropped

    big_start();
    d = '0;
    d[B_DW-1 -: 40]  = mk(1, 1, 1, 0, 0);
    d[B_DW-41 -: 40] = mk(1, 0, 0, 0, 0);
    chk("b_single_pre_valid", b_if.out_valid, 0);
    big_send(d, w);
    chk("b_single_valid", b_if.out_valid, 1);
    chk("b_single_bits", b_if.out_bits, 24'h800000);
    chk("b_single_ch", b_if.out_ch, 0);
    chk("b_single_grp", b_if.out_grp, 0);
    for (int k = 1; k < 432; k++) begin
      gen_rand(d);
      if (k == 60) begin
        // hold the pending result for five cycles with a beat waiting
        b_if.out_ready = 1'b0;
        b_if.in_data   = d;
        b_if.in_valid  = 1'b1;
        repeat (5) begin
          #1;
          chk("b_bp_in_ready", b_if.in_ready, 0);
          @(posedge clk); #1;
          chk("b_bp_valid", b_if.out_valid, 1);
          chk("b_bp_bits", b_if.out_bits, b_q[0].bits);
          chk("b_bp_ch", b_if.out_ch, b_q[0].ch);
          chk("b_bp_grp", b_if.out_grp, b_q[0].grp);
        end
        b_if.out_ready = 1'b1;
      end
      if (k == 70) begin
        start_b = 1'b1; we_b = 1'b1; addr_b = 5'd5; off_b = 12'd2000;
      end
      big_send(d, w);
      start_b = 1'b0; we_b = 1'b0;
      if (k >= 60 && k <= 63) begin
        chk("b_thru_wait", w, 0);
        chk("b_thru_valid", b_if.out_valid, 1);
      end
    end
    big_finish();

    // ---------- frame 2: reset mid-frame with a result pending ----------
    big_start();
    for (int k = 0; k < 30; k++) begin
      gen_rand(d);
      big_send(d, w);
    end
    b_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_mid_rst_valid", b_if.out_valid, 0);
    chk("b_mid_rst_in_ready", b_if.in_ready, 0);
    chk("b_mid_rst_bits", b_if.out_bits, 0);
    chk("b_mid_rst_ch", b_if.out_ch, 0);
    chk("b_mid_rst_grp", b_if.out_grp, 0);
    chk("b_mid_rst_last", b_if.out_last, 0);
    chk("b_mid_rst_busy", busy_b, 0);
    chk("b_mid_rst_done", fd_b, 0);
    b_q.delete();
    rst_b = 1'b0;
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b1;
    for (int c = 0; c < 18; c++) off_m[c] = 0;
    @(posedge clk); #1;
    chk("b_after_rst_busy", busy_b, 0);

    // ---------- frame 3: clean frame, offsets cleared by reset ----------
    big_start();
    for (int k = 0; k < 432; k++) begin
      gen_rand(d);
      big_send(d, w);
    end
    big_finish();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/accbin_stream.md
Name: accbin_stream

Overview:
- Time-multiplexed, parametrised accumulate-and-binarise stage for the binary CNN convolution layers.
- Consumes streamed XOR/popcount partial-sum terms for LANES output pixels per beat.
- Accumulates them over ACC_BEATS beats, adds a per-channel signed offset, and emits one sign bit per pixel.
- Replaces a fully unrolled per-channel array: one instance walks all N_CH channels × N_PIX pixels of a frame, so the same block serves multi-input-channel layers.

Parameters:
- BW, 8, width of each signed partial-sum term
- TERMS, 5, terms per pixel per beat
- LANES, 24, pixels processed per beat
- N_CH, 18, output channels per frame
- N_PIX, 576, pixels per channel; must be a multiple of LANES
- ACC_BEATS, 1, input beats accumulated per pixel group; must be ≥ 1
- ACCW, BW+$clog2(TERMS*ACC_BEATS)+1, accumulator/offset width (signed)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse that begins a frame (honoured in IDLE only)
- cfg_we  input  1  offset write strobe
- cfg_addr  input  $clog2(N_CH)  channel index for the offset write
- cfg_offset  input  ACCW  signed per-channel offset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid&&in_ready
- in_data  input  LANES*TERMS*BW  signed terms; lane 0 term 0 in the MSBs, descending
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accept
- out_bits  output  LANES  binarised pixels; lane 0 in the MSB
- out_ch  output  $clog2(N_CH)  channel of out_bits
- out_grp  output  $clog2(N_PIX/LANES)  pixel group of out_bits
- out_last  output  1  high on the final beat of the frame
- busy  output  1  high in RUN and DRAIN
- frame_done  output  1  one-cycle pulse when the out_last beat is accepted

Behaviour:
- **Reset values:** in_ready=0, out_valid=0, out_bits=0, out_ch=0, out_grp=0, out_last=0, busy=0, frame_done=0. Counters clear and state goes to IDLE. The offset RAM is cleared to 0.
- **Reset mid-frame:** aborts the frame and drops any pending output.
- **IDLE:**
  - cfg_we writes cfg_offset to offset[cfg_addr]; addresses ≥ N_CH are ignored.
  - start → RUN, with beat, grp and ch counters = 0 and the accumulator cleared.
- **Config writes outside IDLE:** ignored.
- **Start outside IDLE:** ignored.
- **RUN, input acceptance:**
  - in_ready = !out_valid || out_ready.
  - On accept, each lane's TERMS terms are sign-extended to ACCW and summed into acc[lane].
  - On the first beat of a group (beat==0), the sum overwrites acc[lane] rather than adding to it.
- **RUN, final beat of a group (beat==ACC_BEATS-1):**
  - sum = acc[lane] + this beat's terms + offset[ch], computed at ACCW+1 bits.
  - out_bits[lane] = (sum ≥ 0).
  - out_ch and out_grp take the current counters; out_valid=1 on the next cycle (latency 1 cycle from the final accepted beat).
  - out_last=1 when ch==N_CH-1 and grp==N_PIX/LANES-1.
- **Counter order:** beat is innermost, then grp, then ch. Each wraps to 0 on reaching its terminal count. When ch wraps, state → DRAIN.
- **DRAIN:** in_ready=0.
  - When the out_last beat is accepted: frame_done=1 for one cycle, then state → IDLE.
- **Output hold:** out_valid stays high and all out_* signals are held stable until out_ready is sampled high.
- **Simultaneous accept-and-refill:** the output register may be accepted and refilled in the same cycle. Full throughput is one beat per clock when out_ready is held high.
- **Arithmetic:** no saturation is needed; ACCW is sized for the worst case. Offsets wider than the term sum are used directly.
- **Stalls:** in_valid low stalls the counters; no bubble-state is lost.

Test Plan:
- **Reset defaults:** assert rst for 2 cycles with in_valid=1 and start=1 → all outputs 0, state IDLE, no beat accepted.
- **Single group, default parameters:**
  - offset[0]=-3; lane 0 terms {1,1,1,0,0} → sum 0 → bit 1; lane 1 terms {1,0,0,0,0} → -2 → bit 0.
  - out_ch=0, out_grp=0, out_valid exactly one cycle after the accepted beat.
- **ACC_BEATS=3, LANES=2, N_PIX=4, N_CH=2:**
  - Per-beat lane-0 terms sum to +4, -6, +1 with offset 0 → sum -1 → bit 0.
  - Same beats with offset +1 → bit 1.
  - The accumulator clears between groups: the second group's result is independent of the first.
- **Backpressure:** hold out_ready=0 for 5 cycles with out_valid=1 → in_ready=0, out_* stable, no input consumed. Release → beat accepted and the next result follows at 1 beat/cycle.
- **Full frame, default parameters:** stream 18×24 beats with random terms, compare against a reference model → 432 output beats.
  - out_ch/out_grp sequence is 0/0 … 17/23.
  - out_last only on the final beat; frame_done one cycle after its acceptance; busy falls and IDLE is re-entered.
- **Ignored controls:** cfg_we to ch 5 mid-RUN and start mid-RUN → offset[5] unchanged, frame unaffected. cfg_addr=18 in IDLE → no write. rst asserted mid-frame → outputs to reset values, and a new start runs a clean frame.
